// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Single-port data-memory responder for an RV32I core. Accepts one load or
// store at a time, waits a fixed number of cycles, then commits the store
// or samples the load and holds the response until the core takes it.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit storage words (power of two, 16..4096)
//   LATENCY     : wait cycles between accept and response (0..15)
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset (storage is not cleared)
//   req_valid  : request present          req_ready : request accepted (IDLE)
//   req_we     : 1 = store, 0 = load      req_funct3: RV32I width code
//   req_addr   : byte address             req_wdata : right-aligned store data
//   rsp_valid  : response present         rsp_ready : core takes response
//   rsp_rdata  : extended load data (0 for stores/errors)
//   rsp_err    : request faulted (range, funct3, optional misalignment)
//
// Build option
//   DMEM_MISALIGN_TRAP_EN : when defined, misaligned halfword/word accesses
//   fault; otherwise the low address bits are ignored for those widths.
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
    // One extra count covers the accept cycle, so the response appears
    // LATENCY+1 edges after the accept edge for every LATENCY value.
    localparam logic [4:0]  CNT_INIT  = 5'(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt, cnt_nx;

    logic        cap_we;
    logic [2:0]  cap_f3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic        f3_ok, range_ok, align_ok, fault, commit;
    logic [1:0]  lane;
    logic [AW-1:0] idx;
    logic [31:0] word, load_val, wr_data;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [3:0]  be;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx = WAIT;
                    cnt_nx   = CNT_INIT;
                end
            end
            WAIT: begin
                cnt_nx = cnt - 5'd1;
                if (cnt == 5'd1) state_nx = RESP;
            end
            RESP: begin
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    // Edge that moves WAIT -> RESP: the only edge with side effects.
    assign commit    = (state == WAIT) && (cnt == 5'd1);

    // Request capture; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            cap_we    <= req_we;
            cap_f3    <= req_funct3;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
        end
    end

    // ---------------- decode / datapath ----------------
    always_comb begin
        range_ok = (cap_addr[31:2] < DEPTH_LIM);
        if (cap_we) f3_ok = (cap_f3 == 3'b000) || (cap_f3 == 3'b001) || (cap_f3 == 3'b010);
        else        f3_ok = (cap_f3 == 3'b000) || (cap_f3 == 3'b001) || (cap_f3 == 3'b010)
                         || (cap_f3 == 3'b100) || (cap_f3 == 3'b101);
        lane = cap_addr[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
        align_ok = !((cap_f3[1:0] == 2'b01 && lane[0]) ||
                     (cap_f3[1:0] == 2'b10 && lane != 2'b00));
`else
        align_ok = 1'b1;
        if (cap_f3[1:0] == 2'b01) lane[0] = 1'b0;
        if (cap_f3[1:0] == 2'b10) lane    = 2'b00;
`endif
        fault = !range_ok || !f3_ok || !align_ok;

        idx    = cap_addr[AW+1:2];
        word   = mem[idx];
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = word[{lane[1], 4'b0000} +: 16];

        case (cap_f3)
            3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_val = {{16{half_v[15]}}, half_v};
            3'b100:  load_val = {24'd0, byte_v};
            3'b101:  load_val = {16'd0, half_v};
            default: load_val = word;
        endcase

        // Store data is replicated across lanes; the byte enables pick the lane.
        case (cap_f3[1:0])
            2'b00: begin
                be      = 4'b0001 << lane;
                wr_data = {4{cap_wdata[7:0]}};
            end
            2'b01: begin
                be      = 4'b0011 << lane;
                wr_data = {2{cap_wdata[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                wr_data = cap_wdata;
            end
        endcase
    end

    // Storage: never reset; reset forces IDLE so no write can slip through.
    always_ff @(posedge clk) begin
        if (commit && cap_we && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Response registers, loaded on the edge entering RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_err   <= fault;
            rsp_rdata <= (fault || cap_we) ? 32'd0 : load_val;
        end
    end

endmodule
